mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, is the maximum number of cycles REQ waits for mem_ack_MemAcc before aborting.
REQ-002 Parameter ADDR_W, default 32, is the data-bus address width.
REQ-003 clk_MemAcc  in  1  single clock; all state updates on posedge.
REQ-004 rst_MemAcc  in  1  synchronous, active-high reset.
REQ-005 debug_in_MemAcc / debug_out_MemAcc  in/out  Debug_t  trace record; the output is registered each clock.
REQ-006 valid_in_MemAcc  in  1  the EX/MEM register holds a live instruction.
REQ-007 PC_in_MemAcc  in  32  branch/jump target from EX/MEM.
REQ-008 ALU_in_MemAcc  in  32  effective address.
REQ-009 Rs2_in_MemAcc  in  32  store data.
REQ-010 zero_in_MemAcc, Branch_in_MemAcc, BranchN_in_MemAcc, Jump_in_MemAcc  in  1 each  branch controls.
REQ-011 MemRW_in_MemAcc  in  1  store when 1.
REQ-012 MemtoReg_in_MemAcc  in  2  load when equal to MEMTOREG_LOAD.
REQ-013 mem_req_MemAcc, mem_we_MemAcc  out  1  bus request and write-enable.
REQ-014 mem_addr_MemAcc, mem_wdata_MemAcc  out  ADDR_W/32  bus address and write data.
REQ-015 mem_rdata_MemAcc, mem_ack_MemAcc  in  32/1  bus read data and completion.
REQ-016 stall_out_MemAcc  out  1  freeze upstream stages (drives en of the EX/MEM register low).
REQ-017 PCSrc_out_MemAcc, PC_target_out_MemAcc  out  1/32  redirect request and redirect target.
REQ-018 load_data_out_MemAcc, valid_out_MemAcc, fault_out_MemAcc  out  32/1/1  result toward MEM/WB.

Function
REQ-019 mem_op = valid_in & (MemRW | MemtoReg==MEMTOREG_LOAD); misaligned = ALU_in[1:0]!=0.
REQ-020 The FSM states SHALL be IDLE, REQ and DONE.
REQ-021 IDLE->REQ when mem_op & ~misaligned; the address, write data and write-enable are latched on this edge.
REQ-022 In REQ, mem_req=1 and the bus outputs SHALL hold the latched values and stay stable until ack.
REQ-023 In REQ with mem_ack=1, the FSM SHALL latch mem_rdata (loads only; stores leave it unchanged) and go to DONE.
REQ-024 In REQ, a timeout counter increments each cycle; when it reaches TIMEOUT_CYC-1 without ack, the FSM SHALL go to DONE with fault set and mem_req dropped.
REQ-025 DONE SHALL last exactly one cycle: valid_out=1, fault_out as latched, then return to IDLE.
REQ-026 stall_out = (IDLE & mem_op & ~misaligned) | REQ, and is combinational.
REQ-027 A non-memory valid instruction in IDLE SHALL give valid_out=1 in the same cycle with zero added latency.
REQ-028 A misaligned mem_op in IDLE SHALL give valid_out=1 and fault_out=1 in the same cycle, with no bus request and no stall.
REQ-029 PCSrc = valid_in & ~stall & ((Branch&zero)|(BranchN&~zero)|Jump); PC_target = PC_in.
REQ-030 An ack arriving in IDLE or DONE SHALL be ignored.
REQ-031 A load's latency is 2 + (bus wait cycles) from IDLE acceptance to valid_out.

Reset
REQ-032 On a reset cycle: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, load_data=0, fault=0, valid_out=0, stall=0, PCSrc=0, debug_out=0.
REQ-033 A reset asserted in REQ SHALL abandon the transaction and drop mem_req on the next edge, with no valid_out.

Structure
REQ-034 The MemState_t enum (IDLE/REQ/DONE) and the constant MEMTOREG_LOAD=2'b01 SHALL live in package pcpu.
REQ-035 The timeout counter SHALL be one sub-module, mem_timeout_cnt (clear/enable/expired).
REQ-036 Every bus transaction SHALL be logged via log_data with debug_in.

Verification
REQ-037 Load addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall for 4 cycles, then valid_out=1 with load_data=0xDEADBEEF and fault=0.
REQ-038 Store addr 0x20, data 0x1234, immediate ack -> mem_we=1 during REQ, valid_out in the third cycle, and load_data unchanged.
REQ-039 Load addr 0x102 -> no mem_req, valid_out=1 and fault=1 in the same cycle, stall=0.
REQ-040 Load with no ack -> mem_req for 16 cycles, then DONE with fault=1, then IDLE.
REQ-041 Branch=1, zero=1, PC_in=0x40, non-memory -> PCSrc=1 and PC_target=0x40 in the same cycle; BranchN=1, zero=1 -> PCSrc=0.
REQ-042 Reset in the second REQ cycle -> mem_req=0 on the next edge, all outputs at reset values, and no valid_out.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared pipeline types for the MEM stage: FSM states, load selector constant,
// the trace record and the helper that stamps bus transactions into it.
package pcpu;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } MemState_t;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
  } Debug_t;

  // Tag a trace record with the bus transaction that this instruction starts.
  function automatic Debug_t log_data(input Debug_t d, input logic [31:0] addr,
                                      input logic we);
    Debug_t r;
    r           = d;
    r.mem_valid = 1'b1;
    r.mem_we    = we;
    r.mem_addr  = addr;
    return r;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus-wait watchdog: counts cycles while enabled, flags the last allowed cycle.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_MemAcc,
  input  logic rst_MemAcc,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_MemAcc) begin
    if (rst_MemAcc || clear) count <= '0;
    else if (enable)         count <= count + 1'b1;
  end

  assign expired = (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs one bus transaction per memory instruction, stalls
// upstream while waiting, and resolves branches for instructions that do not stall.
module mem_access
  import pcpu::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32   // must not exceed 32 (taken from the ALU result)
) (
  input  logic              clk_MemAcc,
  input  logic              rst_MemAcc,
  input  Debug_t            debug_in_MemAcc,
  output Debug_t            debug_out_MemAcc,
  input  logic              valid_in_MemAcc,
  input  logic [31:0]       PC_in_MemAcc,
  input  logic [31:0]       ALU_in_MemAcc,
  input  logic [31:0]       Rs2_in_MemAcc,
  input  logic              zero_in_MemAcc,
  input  logic              Branch_in_MemAcc,
  input  logic              BranchN_in_MemAcc,
  input  logic              Jump_in_MemAcc,
  input  logic              MemRW_in_MemAcc,
  input  logic [1:0]        MemtoReg_in_MemAcc,
  output logic              mem_req_MemAcc,
  output logic              mem_we_MemAcc,
  output logic [ADDR_W-1:0] mem_addr_MemAcc,
  output logic [31:0]       mem_wdata_MemAcc,
  input  logic [31:0]       mem_rdata_MemAcc,
  input  logic              mem_ack_MemAcc,
  output logic              stall_out_MemAcc,
  output logic              PCSrc_out_MemAcc,
  output logic [31:0]       PC_target_out_MemAcc,
  output logic [31:0]       load_data_out_MemAcc,
  output logic              valid_out_MemAcc,
  output logic              fault_out_MemAcc
);

  MemState_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              is_load_q;
  logic [31:0]       load_q;
  logic              fault_q;
  Debug_t            debug_q;

  logic mem_op, misaligned, start, stall_int, expired;

  assign mem_op     = valid_in_MemAcc &
                      (MemRW_in_MemAcc | (MemtoReg_in_MemAcc == MEMTOREG_LOAD));
  assign misaligned = |ALU_in_MemAcc[1:0];
  assign start      = (state_q == IDLE) & mem_op & ~misaligned;
  assign stall_int  = start | (state_q == REQ);

  mem_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_MemAcc (clk_MemAcc),
    .rst_MemAcc (rst_MemAcc),
    .clear      (state_q != REQ),
    .enable     (state_q == REQ),
    .expired    (expired)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (mem_ack_MemAcc || expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_MemAcc) begin
    if (rst_MemAcc) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      load_q    <= '0;
      fault_q   <= 1'b0;
      debug_q   <= '0;
    end else begin
      state_q <= state_d;
      debug_q <= start ? log_data(debug_in_MemAcc, ALU_in_MemAcc, MemRW_in_MemAcc)
                       : debug_in_MemAcc;
      if (start) begin
        addr_q    <= ALU_in_MemAcc[ADDR_W-1:0];
        wdata_q   <= Rs2_in_MemAcc;
        we_q      <= MemRW_in_MemAcc;
        is_load_q <= (MemtoReg_in_MemAcc == MEMTOREG_LOAD) & ~MemRW_in_MemAcc;
        fault_q   <= 1'b0;
      end
      // An ack on the watchdog's last cycle still completes the transaction.
      if (state_q == REQ) begin
        if (mem_ack_MemAcc) begin
          if (is_load_q) load_q <= mem_rdata_MemAcc;
        end else if (expired) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

  assign mem_req_MemAcc       = (state_q == REQ);
  assign mem_we_MemAcc        = (state_q == REQ) & we_q;
  assign mem_addr_MemAcc      = addr_q;
  assign mem_wdata_MemAcc     = wdata_q;
  assign load_data_out_MemAcc = load_q;
  assign debug_out_MemAcc     = debug_q;
  assign PC_target_out_MemAcc = PC_in_MemAcc;

  // Combinational handshakes are forced quiet during a reset cycle.
  assign stall_out_MemAcc = ~rst_MemAcc & stall_int;
  assign valid_out_MemAcc = ~rst_MemAcc &
                            ((state_q == DONE) |
                             ((state_q == IDLE) & valid_in_MemAcc & ~start));
  assign fault_out_MemAcc = ~rst_MemAcc &
                            ((state_q == DONE) ? fault_q
                                               : ((state_q == IDLE) & mem_op & misaligned));
  assign PCSrc_out_MemAcc = ~rst_MemAcc & valid_in_MemAcc & ~stall_int &
                            ((Branch_in_MemAcc & zero_in_MemAcc) |
                             (BranchN_in_MemAcc & ~zero_in_MemAcc) |
                             Jump_in_MemAcc);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: scoreboard of expected results checked when
// valid_out fires, plus cycle-level checks of bus, stall and redirect outputs.
module tb_mem_access;
  import pcpu::*;

  logic        clk = 1'b0;
  logic        rst;
  Debug_t      debug_in, debug_out;
  logic        valid_in, zero, branch, branchn, jump, memrw;
  logic [1:0]  memtoreg;
  logic [31:0] pc_in, alu_in, rs2_in, rdata;
  logic        ack;
  logic        mem_req, mem_we, stall, pcsrc, valid_out, fault_out;
  logic [31:0] mem_addr, mem_wdata, pc_target, load_data;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYC(16), .ADDR_W(32)) dut (
    .clk_MemAcc           (clk),
    .rst_MemAcc           (rst),
    .debug_in_MemAcc      (debug_in),
    .debug_out_MemAcc     (debug_out),
    .valid_in_MemAcc      (valid_in),
    .PC_in_MemAcc         (pc_in),
    .ALU_in_MemAcc        (alu_in),
    .Rs2_in_MemAcc        (rs2_in),
    .zero_in_MemAcc       (zero),
    .Branch_in_MemAcc     (branch),
    .BranchN_in_MemAcc    (branchn),
    .Jump_in_MemAcc       (jump),
    .MemRW_in_MemAcc      (memrw),
    .MemtoReg_in_MemAcc   (memtoreg),
    .mem_req_MemAcc       (mem_req),
    .mem_we_MemAcc        (mem_we),
    .mem_addr_MemAcc      (mem_addr),
    .mem_wdata_MemAcc     (mem_wdata),
    .mem_rdata_MemAcc     (rdata),
    .mem_ack_MemAcc       (ack),
    .stall_out_MemAcc     (stall),
    .PCSrc_out_MemAcc     (pcsrc),
    .PC_target_out_MemAcc (pc_target),
    .load_data_out_MemAcc (load_data),
    .valid_out_MemAcc     (valid_out),
    .fault_out_MemAcc     (fault_out)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard whenever the stage reports a result.
  task automatic monitor(input string tag);
    exp_t e;
    if (valid_out === 1'b1) begin
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_fault"}, fault_out, e.fault);
        if (e.chk_data) check({tag, "_load_data"}, load_data, e.data);
      end
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clear_inputs;
    valid_in = 1'b0; zero = 1'b0; branch = 1'b0; branchn = 1'b0; jump = 1'b0;
    memrw = 1'b0; memtoreg = 2'b00; pc_in = '0; alu_in = '0; rs2_in = '0;
    rdata = '0; ack = 1'b0; debug_in = '0;
  endtask

  initial begin
    Debug_t dbg_a, dbg_exp;
    int     stall_cnt, req_cnt;
    logic   done_seen;

    clear_inputs();
    rst = 1'b1;
    // Live branch and trace input during reset must not leak to any output.
    valid_in = 1'b1; branch = 1'b1; zero = 1'b1; pc_in = 32'h40;
    debug_in = '{pc: 32'h11, instr: 32'h22, mem_valid: 1'b0, mem_we: 1'b0, mem_addr: 32'h0};
    next_cycle(); next_cycle(); settle();
    check("rst_mem_req",   mem_req,   1'b0);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_mem_addr",  mem_addr,  32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_fault",     fault_out, 1'b0);
    check("rst_valid",     valid_out, 1'b0);
    check("rst_stall",     stall,     1'b0);
    check("rst_pcsrc",     pcsrc,     1'b0);
    check("rst_debug",     debug_out, 98'h0);

    // Branch resolution for non-memory instructions, same cycle.
    next_cycle(); rst = 1'b0; clear_inputs();
    valid_in = 1'b1; branch = 1'b1; zero = 1'b1; pc_in = 32'h40;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    settle();
    check("beq_pcsrc",  pcsrc,     1'b1);
    check("beq_target", pc_target, 32'h40);
    check("beq_valid",  valid_out, 1'b1);
    check("beq_stall",  stall,     1'b0);
    monitor("beq");

    next_cycle(); clear_inputs();
    valid_in = 1'b1; branchn = 1'b1; zero = 1'b1; pc_in = 32'h80;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    settle();
    check("bne_taken_pcsrc", pcsrc, 1'b0);
    check("bne_valid", valid_out, 1'b1);
    monitor("bne");

    next_cycle(); clear_inputs();
    valid_in = 1'b1; branchn = 1'b1; zero = 1'b0; pc_in = 32'hC0;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    settle();
    check("bne_nz_pcsrc",  pcsrc,     1'b1);
    check("bne_nz_target", pc_target, 32'hC0);
    monitor("bne_nz");

    next_cycle(); clear_inputs();
    valid_in = 1'b1; jump = 1'b1; pc_in = 32'h100;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    settle();
    check("jump_pcsrc", pcsrc, 1'b1);
    monitor("jump");

    // Misaligned load: immediate fault, no bus activity, no stall.
    next_cycle(); clear_inputs();
    valid_in = 1'b1; memtoreg = MEMTOREG_LOAD; alu_in = 32'h102;
    sb.push_back('{32'h0, 1'b1, 1'b0});
    settle();
    check("mis_mem_req", mem_req,   1'b0);
    check("mis_stall",   stall,     1'b0);
    check("mis_valid",   valid_out, 1'b1);
    monitor("mis");
    next_cycle(); clear_inputs(); settle();
    check("mis_no_req_after", mem_req, 1'b0);

    // Aligned load, ack in the third REQ cycle.
    next_cycle(); clear_inputs();
    dbg_a = '{pc: 32'hA0, instr: 32'h0001_2083, mem_valid: 1'b0, mem_we: 1'b0, mem_addr: 32'h0};
    valid_in = 1'b1; memtoreg = MEMTOREG_LOAD; alu_in = 32'h100; debug_in = dbg_a;
    sb.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
    settle();
    check("ld_accept_stall", stall,     1'b1);
    check("ld_accept_valid", valid_out, 1'b0);
    check("ld_accept_req",   mem_req,   1'b0);
    stall_cnt = int'(stall);
    dbg_exp = dbg_a;
    dbg_exp.mem_valid = 1'b1;
    dbg_exp.mem_we    = 1'b0;
    dbg_exp.mem_addr  = 32'h100;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      ack   = (k == 3);
      rdata = (k == 3) ? 32'hDEADBEEF : 32'h0BAD_0BAD;
      settle();
      check("ld_req",   mem_req,   1'b1);
      check("ld_addr",  mem_addr,  32'h100);
      check("ld_we",    mem_we,    1'b0);
      check("ld_valid", valid_out, 1'b0);
      if (k == 1) check("ld_debug_log", debug_out, dbg_exp);
      stall_cnt += int'(stall);
      monitor("ld");
    end
    next_cycle(); ack = 1'b0; rdata = '0; settle();
    stall_cnt += int'(stall);
    check("ld_done_valid", valid_out, 1'b1);
    check("ld_done_req",   mem_req,   1'b0);
    check("ld_stall_cycles", stall_cnt, 4);
    monitor("ld");

    // A stray ack while idle is ignored.
    next_cycle(); clear_inputs(); ack = 1'b1; rdata = 32'hFFFF_FFFF; settle();
    check("idle_ack_valid", valid_out, 1'b0);
    check("idle_ack_stall", stall,     1'b0);
    next_cycle(); ack = 1'b0; settle();
    check("idle_ack_req",  mem_req,   1'b0);
    check("idle_ack_data", load_data, 32'hDEADBEEF);

    // Store with immediate ack; read data must not be captured.
    next_cycle(); clear_inputs();
    valid_in = 1'b1; memrw = 1'b1; alu_in = 32'h20; rs2_in = 32'h1234;
    sb.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
    settle();
    check("st_accept_stall", stall, 1'b1);
    next_cycle(); ack = 1'b1; rdata = 32'hFFFF_0000; settle();
    check("st_req",   mem_req,   1'b1);
    check("st_we",    mem_we,    1'b1);
    check("st_addr",  mem_addr,  32'h20);
    check("st_wdata", mem_wdata, 32'h1234);
    monitor("st");
    next_cycle(); ack = 1'b0; settle();
    check("st_done_valid", valid_out, 1'b1);
    check("st_done_we",    mem_we,    1'b0);
    monitor("st");

    // Load that never gets an ack: watchdog abort.
    next_cycle(); clear_inputs();
    valid_in = 1'b1; memtoreg = MEMTOREG_LOAD; alu_in = 32'h200;
    sb.push_back('{32'hDEADBEEF, 1'b1, 1'b1});
    settle();
    req_cnt   = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      next_cycle(); settle();
      if (mem_req === 1'b1) req_cnt++;
      if (valid_out === 1'b1) begin
        done_seen = 1'b1;
        monitor("to");
      end
    end
    check("to_done_seen", done_seen, 1'b1);
    check("to_req_cycles", req_cnt, 16);
    next_cycle(); clear_inputs(); settle();
    check("to_idle_req",   mem_req,   1'b0);
    check("to_idle_stall", stall,     1'b0);
    check("to_idle_valid", valid_out, 1'b0);

    // Reset during the second REQ cycle abandons the transaction.
    next_cycle(); clear_inputs();
    valid_in = 1'b1; memtoreg = MEMTOREG_LOAD; alu_in = 32'h300; rs2_in = 32'h55;
    settle();
    next_cycle(); settle();
    check("rr_first_req", mem_req, 1'b1);
    next_cycle(); rst = 1'b1; settle();
    next_cycle(); rst = 1'b0; clear_inputs(); settle();
    check("rr_mem_req",   mem_req,   1'b0);
    check("rr_mem_addr",  mem_addr,  32'h0);
    check("rr_load_data", load_data, 32'h0);
    check("rr_valid",     valid_out, 1'b0);
    check("rr_stall",     stall,     1'b0);
    check("rr_fault",     fault_out, 1'b0);
    check("rr_debug",     debug_out, 98'h0);
    next_cycle(); settle();
    check("rr_no_valid_later", valid_out, 1'b0);
    check("rr_no_req_later",   mem_req,   1'b0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
